rgb_color_seq: RTL and testbench

//   Upstream source of the R/G/B duty values consumed by the RGB PWM stage.

---
 rtl/rgb_color_seq.sv | 218 +++++++++++++++++++++
 tb/tb_rgb_color_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_color_seq.sv
// Produces the R/G/B duty values for the RGB PWM stage. It debounces the buttons,
// selects manual adjust, hue-wheel fade, white breathe or hold from sw, and strobes upd.
module rgb_color_seq #(
  parameter int DEB_CYCLES = 20000,
  parameter int TICK_DIV   = 50000,
  parameter int STEP       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  output logic [7:0] R_time_out,
  output logic [7:0] G_time_out,
  output logic [7:0] B_time_out,
  output logic       upd,
  output logic [3:0] led
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [8:0]    STEP9     = 9'(STEP);

  typedef enum logic [1:0] {
    MODE_MANUAL  = 2'b00,
    MODE_FADE    = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  logic [1:0]    sw_s1_q, sw_s2_q;
  mode_e         mode_q;
  logic [2:0]    btn_raw_s, btn_s1_q, btn_s2_q, btn_stable_q, btn_dly_q, press_q;
  logic [DW-1:0] deb_cnt_q [3];
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    r_q, g_q, b_q, r_d, g_d, b_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    phase_q, phase_d;
  logic          dir_q, dir_d, tgl_q, tgl_d, upd_q;
  logic          mode_chg_s, anim_s, tick_s;
  logic [7:0]    cur_s, adj_s, breath_s;
  logic [8:0]    sum_s, diff_s;

  assign btn_raw_s = {btn_sel, btn_down, btn_up};

  // Input synchronisers, mode history and per-button debounce with press pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_s1_q      <= 2'b00;
      sw_s2_q      <= 2'b00;
      mode_q       <= MODE_MANUAL;
      btn_s1_q     <= 3'b000;
      btn_s2_q     <= 3'b000;
      btn_stable_q <= 3'b000;
      btn_dly_q    <= 3'b000;
      press_q      <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
    end else begin
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      mode_q    <= mode_e'(sw_s2_q);
      btn_s1_q  <= btn_raw_s;
      btn_s2_q  <= btn_s1_q;
      btn_dly_q <= btn_stable_q;
      press_q   <= btn_stable_q & ~btn_dly_q;
      for (int i = 0; i < 3; i++) begin
        if (btn_s2_q[i] != btn_stable_q[i]) begin
          if (deb_cnt_q[i] == DEB_LAST) begin
            btn_stable_q[i] <= btn_s2_q[i];
            deb_cnt_q[i]    <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign mode_chg_s = (sw_s2_q != mode_q);
  assign anim_s     = (mode_q == MODE_FADE) || (mode_q == MODE_BREATHE);
  assign tick_s     = anim_s && !mode_chg_s && (tick_cnt_q == TICK_LAST);
  assign breath_s   = dir_q ? (r_q + 8'd1) : (r_q - 8'd1);
  assign sum_s      = {1'b0, cur_s} + STEP9;
  assign diff_s     = {1'b0, cur_s} - STEP9;

  // Saturating manual adjust of the currently selected channel.
  always_comb begin
    case (sel_q)
      3'b010:  cur_s = g_q;
      3'b100:  cur_s = b_q;
      default: cur_s = r_q;
    endcase
    if (press_q[0] && !press_q[1]) begin
      adj_s = sum_s[8] ? 8'hFF : sum_s[7:0];
    end else if (press_q[1] && !press_q[0]) begin
      adj_s = diff_s[8] ? 8'h00 : diff_s[7:0];
    end else begin
      adj_s = cur_s;
    end
  end

  // Next-state for duty values, selection, fade phase, breathe direction and tick.
  always_comb begin
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;
    sel_d      = sel_q;
    phase_d    = phase_q;
    dir_d      = dir_q;
    tgl_d      = tgl_q ^ tick_s;
    tick_cnt_d = '0;
    if (mode_chg_s) begin
      case (mode_e'(sw_s2_q))
        MODE_FADE: begin
          r_d     = 8'hFF;
          g_d     = 8'h00;
          b_d     = 8'h00;
          phase_d = 3'd0;
        end
        MODE_BREATHE: begin
          r_d   = 8'h00;
          g_d   = 8'h00;
          b_d   = 8'h00;
          dir_d = 1'b1;
        end
        default: begin
        end
      endcase
    end else begin
      if (anim_s && !tick_s) begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end else begin
        tick_cnt_d = '0;
      end
      case (mode_q)
        MODE_MANUAL: begin
          sel_d = press_q[2] ? {sel_q[1:0], sel_q[2]} : sel_q;
          case (sel_q)
            3'b010:  g_d = adj_s;
            3'b100:  b_d = adj_s;
            default: r_d = adj_s;
          endcase
        end
        MODE_FADE: begin
          // The tick that lands the ramped channel on its endpoint also advances the phase.
          if (tick_s) begin
            case (phase_q)
              3'd0: begin g_d = g_q + 8'd1; phase_d = (g_q == 8'd254) ? 3'd1 : phase_q; end
              3'd1: begin r_d = r_q - 8'd1; phase_d = (r_q == 8'd1)   ? 3'd2 : phase_q; end
              3'd2: begin b_d = b_q + 8'd1; phase_d = (b_q == 8'd254) ? 3'd3 : phase_q; end
              3'd3: begin g_d = g_q - 8'd1; phase_d = (g_q == 8'd1)   ? 3'd4 : phase_q; end
              3'd4: begin r_d = r_q + 8'd1; phase_d = (r_q == 8'd254) ? 3'd5 : phase_q; end
              3'd5: begin b_d = b_q - 8'd1; phase_d = (b_q == 8'd1)   ? 3'd0 : phase_q; end
              default: phase_d = 3'd0;
            endcase
          end else begin
            phase_d = phase_q;
          end
        end
        MODE_BREATHE: begin
          if (tick_s) begin
            r_d = breath_s;
            g_d = breath_s;
            b_d = breath_s;
            if (dir_q && (breath_s == 8'hFF)) begin
              dir_d = 1'b0;
            end else if (!dir_q && (breath_s == 8'h00)) begin
              dir_d = 1'b1;
            end else begin
              dir_d = dir_q;
            end
          end else begin
            dir_d = dir_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output and animation state registers; upd flags any duty change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q        <= 8'h00;
      g_q        <= 8'h00;
      b_q        <= 8'h00;
      sel_q      <= 3'b001;
      phase_q    <= 3'd0;
      dir_q      <= 1'b1;
      tgl_q      <= 1'b0;
      tick_cnt_q <= '0;
      upd_q      <= 1'b0;
    end else begin
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
      phase_q    <= phase_d;
      dir_q      <= dir_d;
      tgl_q      <= tgl_d;
      tick_cnt_q <= tick_cnt_d;
      upd_q      <= (r_d != r_q) || (g_d != g_q) || (b_d != b_q);
    end
  end

  assign R_time_out = r_q;
  assign G_time_out = g_q;
  assign B_time_out = b_q;
  assign upd        = upd_q;
  assign led        = {tgl_q, sel_q};

endmodule

// File: tb/tb_rgb_color_seq.sv
// Self-checking bench for rgb_color_seq with small debounce/tick parameters,
// using a colour-wheel / breathe-curve model and a per-press manual model.
module tb_rgb_color_seq;

  localparam int DEB = 4;
  localparam int TDIV = 2;
  localparam int STEP = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw;
  logic       btn_up, btn_down, btn_sel;
  logic [7:0] R_time_out, G_time_out, B_time_out;
  logic       upd;
  logic [3:0] led;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_seen = 0;

  rgb_color_seq #(.DEB_CYCLES(DEB), .TICK_DIV(TDIV), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .R_time_out(R_time_out), .G_time_out(G_time_out), .B_time_out(B_time_out),
    .upd(upd), .led(led)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (upd === 1'b1) upd_seen++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; sw = 2'b00; btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
  endtask

  task automatic press(input logic u, input logic d, input logic s);
    btn_up = u; btn_down = d; btn_sel = s;
    step(8);
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    step(12);
  endtask

  // Colour after k fade ticks: six 255-tick ramps around the hue wheel.
  function automatic logic [23:0] wheel(input int k);
    int m, s, t, r, g, b;
    m = k % 1530; s = m / 255; t = m % 255;
    case (s)
      0: begin r = 255;     g = t;       b = 0;       end
      1: begin r = 255 - t; g = 255;     b = 0;       end
      2: begin r = 0;       g = 255;     b = t;       end
      3: begin r = 0;       g = 255 - t; b = 255;     end
      4: begin r = t;       g = 0;       b = 255;     end
      default: begin r = 255; g = 0;     b = 255 - t; end
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic logic [7:0] breathe(input int k);
    int m;
    m = k % 510;
    return (m <= 255) ? 8'(m) : 8'(510 - m);
  endfunction

  task automatic test_reset();
    rst = 1'b0; sw = 2'b00; btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    step(3);
    n_tests++;
    if ({R_time_out, G_time_out, B_time_out, led, upd} !== {24'h000000, 4'b0001, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got rgb=%h led=%b upd=%b want rgb=000000 led=0001 upd=0",
               {R_time_out, G_time_out, B_time_out}, led, upd);
    end
    rst = 1'b1; upd_seen = 0;
    step(10);
    n_tests++;
    if ({R_time_out, G_time_out, B_time_out, led} !== {24'h000000, 4'b0001} || upd_seen != 0) begin
      n_fail++;
      $display("FAIL reset_idle got rgb=%h led=%b upd_pulses=%0d want rgb=000000 led=0001 upd_pulses=0",
               {R_time_out, G_time_out, B_time_out}, led, upd_seen);
    end
  endtask

  task automatic test_debounce();
    do_reset();
    btn_up = 1'b1; step(3); btn_up = 1'b0; upd_seen = 0; step(15);
    n_tests++;
    if (R_time_out !== 8'd0 || upd_seen != 0) begin
      n_fail++;
      $display("FAIL deb_short got R=%0d upd_pulses=%0d want R=0 upd_pulses=0", R_time_out, upd_seen);
    end
    btn_up = 1'b1; upd_seen = 0;
    step(DEB + 3);
    n_tests++;
    if (R_time_out !== 8'd0) begin
      n_fail++;
      $display("FAIL deb_early got R=%0d want 0 at edge %0d", R_time_out, DEB + 3);
    end
    step(1);
    n_tests++;
    if (R_time_out !== 8'd16 || upd !== 1'b1) begin
      n_fail++;
      $display("FAIL deb_latency got R=%0d upd=%b want R=16 upd=1 at edge %0d", R_time_out, upd, DEB + 4);
    end
    step(20 - (DEB + 4));
    btn_up = 1'b0;
    step(15);
    n_tests++;
    if (R_time_out !== 8'd16 || upd_seen != 1) begin
      n_fail++;
      $display("FAIL deb_long got R=%0d upd_pulses=%0d want R=16 upd_pulses=1", R_time_out, upd_seen);
    end
  endtask

  task automatic test_saturation();
    int exp_r;
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      exp_r = (16 * i > 255) ? 255 : 16 * i;
      upd_seen = 0;
      press(1'b1, 1'b0, 1'b0);
      n_tests++;
      if (R_time_out !== 8'(exp_r) || upd_seen != ((i <= 16) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL sat_up press=%0d got R=%0d upd_pulses=%0d want R=%0d upd_pulses=%0d",
                 i, R_time_out, upd_seen, exp_r, (i <= 16) ? 1 : 0);
      end
    end
    press(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (led[2:0] !== 3'b010) begin
      n_fail++;
      $display("FAIL sel_rotate got led=%b want 010", led[2:0]);
    end
    upd_seen = 0;
    press(1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({R_time_out, G_time_out} !== {8'd255, 8'd0} || upd_seen != 0) begin
      n_fail++;
      $display("FAIL sat_down got R=%0d G=%0d upd_pulses=%0d want R=255 G=0 upd_pulses=0",
               R_time_out, G_time_out, upd_seen);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    upd_seen = 0;
    press(1'b1, 1'b1, 1'b0);
    n_tests++;
    if ({R_time_out, G_time_out, B_time_out, led} !== {24'h000000, 4'b0001} || upd_seen != 0) begin
      n_fail++;
      $display("FAIL up_down got rgb=%h led=%b upd_pulses=%0d want rgb=000000 led=0001 upd_pulses=0",
               {R_time_out, G_time_out, B_time_out}, led, upd_seen);
    end
    upd_seen = 0;
    press(1'b1, 1'b0, 1'b1);
    n_tests++;
    if ({R_time_out, G_time_out, B_time_out, led} !== {24'h100000, 4'b0010} || upd_seen != 1) begin
      n_fail++;
      $display("FAIL up_sel got rgb=%h led=%b upd_pulses=%0d want rgb=100000 led=0010 upd_pulses=1",
               {R_time_out, G_time_out, B_time_out}, led, upd_seen);
    end
  endtask

  task automatic test_manual_random();
    int ch[3];
    int sel, old, nv, changed;
    logic [2:0] b;
    do_reset();
    ch[0] = 0; ch[1] = 0; ch[2] = 0; sel = 0;
    for (int i = 0; i < 40; i++) begin
      b = 3'($urandom_range(1, 7));
      old = ch[sel]; nv = old;
      if (b[0] && !b[1]) nv = (old + STEP > 255) ? 255 : old + STEP;
      if (b[1] && !b[0]) nv = (old - STEP < 0) ? 0 : old - STEP;
      changed = (nv != old) ? 1 : 0;
      ch[sel] = nv;
      if (b[2]) sel = (sel + 1) % 3;
      upd_seen = 0;
      press(b[0], b[1], b[2]);
      n_tests++;
      if ({R_time_out, G_time_out, B_time_out} !== {8'(ch[0]), 8'(ch[1]), 8'(ch[2])} ||
          led[2:0] !== 3'(1 << sel) || upd_seen != changed) begin
        n_fail++;
        $display("FAIL manual_rand i=%0d btn=%b got rgb=%h led=%b upd_pulses=%0d want rgb=%h led=%b upd_pulses=%0d",
                 i, b, {R_time_out, G_time_out, B_time_out}, led[2:0], upd_seen,
                 {8'(ch[0]), 8'(ch[1]), 8'(ch[2])}, 3'(1 << sel), changed);
      end
    end
  endtask

  task automatic test_fade();
    int k;
    do_reset();
    sw = 2'b01;
    step(3);
    n_tests++;
    if ({R_time_out, G_time_out, B_time_out} !== 24'hFF0000 || upd !== 1'b1) begin
      n_fail++;
      $display("FAIL fade_entry got rgb=%h upd=%b want rgb=ff0000 upd=1",
               {R_time_out, G_time_out, B_time_out}, upd);
    end
    for (int n = 1; n <= 2 * 1530; n++) begin
      step(1);
      k = n / TDIV;
      n_tests++;
      if ({R_time_out, G_time_out, B_time_out} !== wheel(k) || upd !== ((n % TDIV) == 0) ||
          led[3] !== k[0]) begin
        n_fail++;
        $display("FAIL fade n=%0d got rgb=%h upd=%b led3=%b want rgb=%h upd=%b led3=%b",
                 n, {R_time_out, G_time_out, B_time_out}, upd, led[3], wheel(k),
                 (n % TDIV) == 0, k[0]);
      end
    end
  endtask

  task automatic test_breathe_hold();
    int k, extra, nf;
    logic [7:0] v;
    do_reset();
    sw = 2'b10;
    step(3);
    n_tests++;
    if ({R_time_out, G_time_out, B_time_out} !== 24'h000000 || upd !== 1'b0) begin
      n_fail++;
      $display("FAIL breathe_entry got rgb=%h upd=%b want rgb=000000 upd=0",
               {R_time_out, G_time_out, B_time_out}, upd);
    end
    extra = $urandom_range(40, 200);
    for (int n = 1; n <= 1020 + extra; n++) begin
      step(1);
      k = n / TDIV;
      v = breathe(k);
      n_tests++;
      if ({R_time_out, G_time_out, B_time_out} !== {v, v, v} || upd !== ((n % TDIV) == 0)) begin
        n_fail++;
        $display("FAIL breathe n=%0d got rgb=%h upd=%b want rgb=%h upd=%b",
                 n, {R_time_out, G_time_out, B_time_out}, upd, {v, v, v}, (n % TDIV) == 0);
      end
    end
    sw = 2'b11;
    step(3);
    nf = 1020 + extra + 2;
    k = nf / TDIV;
    v = breathe(k);
    upd_seen = 0;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b1);
    n_tests++;
    if ({R_time_out, G_time_out, B_time_out} !== {v, v, v} || upd_seen != 0 ||
        led !== {k[0], 3'b001}) begin
      n_fail++;
      $display("FAIL hold got rgb=%h led=%b upd_pulses=%0d want rgb=%h led=%b upd_pulses=0",
               {R_time_out, G_time_out, B_time_out}, led, upd_seen, {v, v, v}, {k[0], 3'b001});
    end
  endtask

  task automatic test_reset_mid_fade();
    do_reset();
    sw = 2'b01;
    step(3 + $urandom_range(10, 100));
    rst = 1'b0;
    step(1);
    n_tests++;
    if ({R_time_out, G_time_out, B_time_out, led, upd} !== {24'h000000, 4'b0001, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_fade got rgb=%h led=%b upd=%b want rgb=000000 led=0001 upd=0",
               {R_time_out, G_time_out, B_time_out}, led, upd);
    end
    rst = 1'b1; sw = 2'b00;
    step(5);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_saturation();
    test_simultaneous();
    test_manual_random();
    test_fade();
    test_breathe_hold();
    test_reset_mid_fade();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
